// File: rtl/usb_pkg.sv
// Shared definitions for the low-speed USB receive path.
package usb_pkg;

    // Synchronized line state as seen by the receiver.
    typedef enum logic [1:0] {
        LS_J   = 2'd0,
        LS_K   = 2'd1,
        LS_SE0 = 2'd2
    } line_state_t;

    // Receive framing state machine.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_DATA   = 3'd2,
        ST_EOP    = 3'd3,
        ST_WAIT_J = 3'd4
    } rx_state_t;

    // Consecutive decoded ones after which the transmitter inserts a zero.
    localparam int STUFF_LIMIT = 6;

endpackage

// File: rtl/usb_rx_dpll.sv
// Pad synchronizer and bit-clock recovery: derives the line state and
// pulses o_sample once per bit, re-aligned on every line transition.
module usb_rx_dpll
    import usb_pkg::*;
#(
    parameter int OVERSAMPLE   = 10,
    parameter int SAMPLE_PHASE = 5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_usb_j_not_k,
    input  logic       i_usb_se0,
    output logic [1:0] o_line_state,
    output logic       o_se0,
    output logic       o_sample
);

    localparam int PW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic          j_meta;
    logic          j_s;
    logic          se0_meta;
    logic          se0_s;
    line_state_t   line_state;
    line_state_t   line_prev;
    logic [PW-1:0] phase;

    // Two-flop synchronizers; idle bus (J, no SE0) is the reset value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            j_meta   <= 1'b1;
            j_s      <= 1'b1;
            se0_meta <= 1'b0;
            se0_s    <= 1'b0;
        end else begin
            j_meta   <= i_usb_j_not_k;
            j_s      <= j_meta;
            se0_meta <= i_usb_se0;
            se0_s    <= se0_meta;
        end
    end

    // SE0 overrides the differential state.
    always_comb begin
        line_state = se0_s ? LS_SE0 : (j_s ? LS_J : LS_K);
    end

    // Phase counter restarts on every line-state change, otherwise free-runs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            line_prev <= LS_J;
            phase     <= '0;
        end else begin
            line_prev <= line_state;
            if (line_state != line_prev) begin
                phase <= '0;
            end else if (phase == PW'(OVERSAMPLE - 1)) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    assign o_line_state = line_state;
    assign o_se0        = se0_s;
    assign o_sample     = (phase == PW'(SAMPLE_PHASE));

endmodule

// File: rtl/usb_rx_phy.sv
// Low-speed USB receive front end: SYNC detection, NRZI decode, bit
// unstuffing, byte assembly, EOP framing and bus-reset detection.
module usb_rx_phy
    import usb_pkg::*;
#(
    parameter int OVERSAMPLE     = 10,
    parameter int SAMPLE_PHASE   = 5,
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int RESET_CYCLES   = 38
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_usb_j_not_k,
    input  logic       i_usb_se0,
    input  logic       i_tx_active,
    output logic       o_active,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_eop,
    output logic       o_err,
    output logic       o_usb_reset
);

    localparam int RW = $clog2(RESET_CYCLES + 1);

    logic [1:0] ls;
    logic       se0_s;
    logic       sample;

    usb_rx_dpll #(
        .OVERSAMPLE   (OVERSAMPLE),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_dpll (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_usb_j_not_k (i_usb_j_not_k),
        .i_usb_se0     (i_usb_se0),
        .o_line_state  (ls),
        .o_se0         (se0_s),
        .o_sample      (sample)
    );

    rx_state_t  state,     state_n;
    logic [3:0] zero_cnt,  zero_cnt_n;
    logic       prev_j,    prev_j_n;
    logic [2:0] bit_cnt,   bit_cnt_n;
    logic [2:0] ones_cnt,  ones_cnt_n;
    logic [1:0] se0_bits,  se0_bits_n;
    logic       partial,   partial_n;
    logic [7:0] shift,     shift_n;
    logic       active_p1, active_n;
    logic [7:0] data_p1,   data_n;
    logic       vld_p1,    vld_n;
    logic       eop_p1,    eop_n;
    logic       err_p1,    err_n;

    logic       is_se0;
    logic       is_j;
    logic       dec;

    logic [RW-1:0] se0_cnt;
    logic          usb_reset_q;

    // Framing and control registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            zero_cnt  <= '0;
            prev_j    <= 1'b1;
            bit_cnt   <= '0;
            ones_cnt  <= '0;
            se0_bits  <= '0;
            partial   <= 1'b0;
            active_p1 <= 1'b0;
            data_p1   <= '0;
            vld_p1    <= 1'b0;
            eop_p1    <= 1'b0;
            err_p1    <= 1'b0;
        end else begin
            state     <= state_n;
            zero_cnt  <= zero_cnt_n;
            prev_j    <= prev_j_n;
            bit_cnt   <= bit_cnt_n;
            ones_cnt  <= ones_cnt_n;
            se0_bits  <= se0_bits_n;
            partial   <= partial_n;
            active_p1 <= active_n;
            data_p1   <= data_n;
            vld_p1    <= vld_n;
            eop_p1    <= eop_n;
            err_p1    <= err_n;
        end
    end

    // Byte shift register; contents are only meaningful once eight bits are in.
    always_ff @(posedge i_clk) begin
        shift <= shift_n;
    end

    // Next-state, NRZI decode, unstuffing and byte assembly for one sample.
    always_comb begin
        state_n    = state;
        zero_cnt_n = zero_cnt;
        prev_j_n   = prev_j;
        bit_cnt_n  = bit_cnt;
        ones_cnt_n = ones_cnt;
        se0_bits_n = se0_bits;
        partial_n  = partial;
        shift_n    = shift;
        active_n   = active_p1;
        data_n     = data_p1;
        vld_n      = 1'b0;
        eop_n      = 1'b0;
        err_n      = 1'b0;

        is_se0 = (ls == LS_SE0);
        is_j   = (ls == LS_J);
        // No transition since the previous J/K sample decodes as a one.
        dec    = (is_j == prev_j);

        if (i_tx_active) begin
            state_n  = ST_IDLE;
            active_n = 1'b0;
        end else if (sample) begin
            if (!is_se0) begin
                prev_j_n = is_j;
            end
            case (state)
                ST_IDLE: begin
                    // The idle J is the implicit previous state, so the first K is the first SYNC zero.
                    if (!is_se0 && !is_j) begin
                        state_n    = ST_SYNC;
                        zero_cnt_n = 4'd1;
                    end
                end
                ST_SYNC: begin
                    if (is_se0) begin
                        state_n = ST_IDLE;
                    end else if (!dec) begin
                        if (zero_cnt != 4'hF) begin
                            zero_cnt_n = zero_cnt + 4'd1;
                        end
                    end else if (zero_cnt >= 4'(SYNC_MIN_ZEROS)) begin
                        state_n    = ST_DATA;
                        active_n   = 1'b1;
                        bit_cnt_n  = '0;
                        ones_cnt_n = '0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (is_se0) begin
                        state_n    = ST_EOP;
                        se0_bits_n = 2'd1;
                        partial_n  = (bit_cnt != 3'd0);
                    end else if (ones_cnt == 3'(STUFF_LIMIT)) begin
                        if (!dec) begin
                            ones_cnt_n = '0;
                        end else begin
                            err_n    = 1'b1;
                            active_n = 1'b0;
                            state_n  = ST_WAIT_J;
                        end
                    end else begin
                        shift_n    = {dec, shift[7:1]};
                        bit_cnt_n  = bit_cnt + 3'd1;
                        ones_cnt_n = dec ? ones_cnt + 3'd1 : 3'd0;
                        if (bit_cnt == 3'd7) begin
                            data_n = shift_n;
                            vld_n  = 1'b1;
                        end
                    end
                end
                ST_EOP: begin
                    if (is_se0) begin
                        if (se0_bits >= 2'd2) begin
                            err_n    = 1'b1;
                            active_n = 1'b0;
                            state_n  = ST_WAIT_J;
                        end else begin
                            se0_bits_n = se0_bits + 2'd1;
                        end
                    end else if (is_j) begin
                        eop_n    = 1'b1;
                        err_n    = partial;
                        active_n = 1'b0;
                        state_n  = ST_IDLE;
                    end else begin
                        err_n    = 1'b1;
                        active_n = 1'b0;
                        state_n  = ST_WAIT_J;
                    end
                end
                ST_WAIT_J: begin
                    if (is_j) begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Bus reset: count consecutive SE0 cycles, saturating at the threshold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            se0_cnt     <= '0;
            usb_reset_q <= 1'b0;
        end else if (!se0_s) begin
            se0_cnt     <= '0;
            usb_reset_q <= 1'b0;
        end else begin
            if (se0_cnt != RW'(RESET_CYCLES)) begin
                se0_cnt <= se0_cnt + 1'b1;
            end
            usb_reset_q <= (se0_cnt >= RW'(RESET_CYCLES - 1));
        end
    end

    // p1: outputs registered one cycle after the deciding sample.
    assign o_active     = active_p1;
    assign o_data       = data_p1;
    assign o_data_valid = vld_p1;
    assign o_eop        = eop_p1;
    assign o_err        = err_p1;
    assign o_usb_reset  = usb_reset_q;

endmodule

// File: tb/tb_usb_rx_phy.sv
// Bench for usb_rx_phy: drives line-level packets and checks the receiver
// against an event scoreboard and a bus-reset run-length model.
module tb_usb_rx_phy;

    localparam int RESET_CYCLES = 38;

    localparam logic [1:0] K_DV     = 2'd0;
    localparam logic [1:0] K_EOP    = 2'd1;
    localparam logic [1:0] K_EOPERR = 2'd2;
    localparam logic [1:0] K_ERR    = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       usb_j;
    logic       usb_se0;
    logic       tx_active;
    logic       o_active;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_eop;
    logic       o_err;
    logic       o_usb_reset;

    int total;
    int bad;

    ev_t  evq[$];
    int   act_mode;   // 0: must be low, 1: must be high, 2: in transition
    int   run_q[3];
    int   n_dv, n_eop, n_err;
    logic [7:0] last_data;

    logic cur_j;
    bit   jitter;
    bit   jtog;
    bit   stuff_en;
    bit   first_data;
    int   ones;

    usb_rx_phy dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_usb_j_not_k (usb_j),
        .i_usb_se0     (usb_se0),
        .i_tx_active   (tx_active),
        .o_active      (o_active),
        .o_data        (o_data),
        .o_data_valid  (o_data_valid),
        .o_eop         (o_eop),
        .o_err         (o_err),
        .o_usb_reset   (o_usb_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int run_now;
        ev_t ev;
        logic [1:0] got_kind;
        run_now = usb_se0 ? run_q[0] + 1 : 0;
        check("usb_reset", {31'd0, o_usb_reset}, {31'd0, run_q[2] >= RESET_CYCLES});
        run_q[2] = run_q[1];
        run_q[1] = run_q[0];
        run_q[0] = run_now;
        if (act_mode != 2) begin
            check("active", {31'd0, o_active}, {31'd0, act_mode == 1});
        end
        if (o_data_valid || o_eop || o_err) begin
            check("strobe_exclusive", {31'd0, o_data_valid & (o_eop | o_err)}, 32'd0);
            got_kind = o_data_valid ? K_DV : (o_eop && o_err) ? K_EOPERR : o_eop ? K_EOP : K_ERR;
            if (o_data_valid) begin n_dv++; last_data = o_data; end
            if (o_eop) n_eop++;
            if (o_err) n_err++;
            if (evq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe got kind=%0d data=0x%0h exp=none", got_kind, o_data);
            end else begin
                ev = evq.pop_front();
                check("event_kind", {30'd0, got_kind}, {30'd0, ev.kind});
                if (ev.kind == K_DV) begin
                    check("event_data", {24'd0, o_data}, {24'd0, ev.data});
                end
            end
        end
    end

    task automatic push(input logic [1:0] kind, input logic [7:0] data);
        evq.push_back('{kind: kind, data: data});
    endtask

    task automatic drive(input logic se0, input logic j, input int cycles);
        usb_se0 = se0;
        usb_j   = j;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    function automatic int bit_len();
        if (!jitter) return 10;
        jtog = !jtog;
        return jtog ? 11 : 9;
    endfunction

    task automatic send_bit(input logic b);
        if (!b) cur_j = !cur_j;
        drive(1'b0, cur_j, bit_len());
    endtask

    task automatic send_sync();
        act_mode   = 2;
        first_data = 1'b1;
        ones       = 0;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_data_bit(input logic b);
        send_bit(b);
        if (first_data) begin
            act_mode   = 1;
            first_data = 1'b0;
        end
        if (stuff_en) begin
            ones = b ? ones + 1 : 0;
            if (ones == 6) begin
                send_bit(1'b0);
                ones = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    endtask

    task automatic send_eop();
        act_mode = 2;
        drive(1'b1, 1'b0, 20);
        cur_j = 1'b1;
        drive(1'b0, 1'b1, 10);
        act_mode = 0;
        drive(1'b0, 1'b1, 20);
    endtask

    task automatic counts(input string name, input int dv0, input int eop0, input int err0,
                          input int dv, input int eop, input int err);
        check({name, "_missing"}, evq.size(), 0);
        check({name, "_dv_count"}, n_dv - dv0, dv);
        check({name, "_eop_count"}, n_eop - eop0, eop);
        check({name, "_err_count"}, n_err - err0, err);
    endtask

    initial begin
        int dv0, eop0, err0;
        total = 0; bad = 0;
        n_dv = 0; n_eop = 0; n_err = 0; last_data = 8'h00;
        run_q[0] = 0; run_q[1] = 0; run_q[2] = 0;
        rst_n = 1'b0; usb_j = 1'b1; usb_se0 = 1'b0; tx_active = 1'b0;
        act_mode = 0; cur_j = 1'b1; jitter = 1'b0; jtog = 1'b0;
        stuff_en = 1'b1; first_data = 1'b0; ones = 0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_active", {31'd0, o_active}, 32'd0);
        check("rst_data", {24'd0, o_data}, 32'd0);
        check("rst_dv", {31'd0, o_data_valid}, 32'd0);
        check("rst_eop", {31'd0, o_eop}, 32'd0);
        check("rst_err", {31'd0, o_err}, 32'd0);
        check("rst_usb_reset", {31'd0, o_usb_reset}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 30);

        // Basic packet: one byte 0xA5.
        dv0 = n_dv; eop0 = n_eop; err0 = n_err;
        push(K_DV, 8'hA5); push(K_EOP, 8'h00);
        send_sync(); send_byte(8'hA5); send_eop();
        counts("pktA", dv0, eop0, err0, 1, 1, 0);
        check("pktA_data", {24'd0, last_data}, 32'h0000_00A5);

        // Stuffed zeros inside 0xFF and straddling into 0x3F.
        dv0 = n_dv; eop0 = n_eop; err0 = n_err;
        push(K_DV, 8'hFF); push(K_DV, 8'h3F); push(K_EOP, 8'h00);
        send_sync(); send_byte(8'hFF); send_byte(8'h3F); send_eop();
        counts("stuff", dv0, eop0, err0, 2, 1, 0);
        check("stuff_last_data", {24'd0, last_data}, 32'h0000_003F);

        // Missing stuff bit after six ones.
        dv0 = n_dv; eop0 = n_eop; err0 = n_err;
        push(K_ERR, 8'h00);
        stuff_en = 1'b0;
        send_sync();
        for (int i = 0; i < 6; i++) send_data_bit(1'b1);
        act_mode = 2;
        send_bit(1'b1);
        act_mode = 0;
        send_bit(1'b0); send_bit(1'b0);
        send_eop();
        stuff_en = 1'b1;
        counts("stufferr", dv0, eop0, err0, 0, 0, 1);

        // Alternating 9/11-cycle bits.
        dv0 = n_dv; eop0 = n_eop; err0 = n_err;
        push(K_DV, 8'h5A); push(K_DV, 8'hC3); push(K_EOP, 8'h00);
        jitter = 1'b1;
        send_sync(); send_byte(8'h5A); send_byte(8'hC3);
        jitter = 1'b0;
        send_eop();
        counts("jitter", dv0, eop0, err0, 2, 1, 0);
        check("jitter_last_data", {24'd0, last_data}, 32'h0000_00C3);

        // Partial byte before EOP.
        dv0 = n_dv; eop0 = n_eop; err0 = n_err;
        push(K_EOPERR, 8'h00);
        send_sync();
        send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1); send_data_bit(1'b1);
        send_eop();
        counts("partial", dv0, eop0, err0, 0, 1, 1);

        // Transmitter takes the bus mid-packet.
        dv0 = n_dv; eop0 = n_eop; err0 = n_err;
        send_sync();
        send_data_bit(1'b1); send_data_bit(1'b0); send_data_bit(1'b1);
        @(negedge clk);
        check("tx_pre_active", {31'd0, o_active}, 32'd1);
        act_mode = 2;
        @(posedge clk); #1;
        tx_active = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("tx_active_drop", {31'd0, o_active}, 32'd0);
        act_mode = 0;
        @(posedge clk); #1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        cur_j = 1'b1;
        drive(1'b0, 1'b1, 30);
        tx_active = 1'b0;
        drive(1'b0, 1'b1, 30);
        counts("txabort", dv0, eop0, err0, 0, 0, 0);

        // SE0 for 40 cycles: reset flag rises 40 cycles after the pad edge.
        @(posedge clk); #1;
        usb_se0 = 1'b1;
        repeat (39) @(posedge clk);
        @(negedge clk);
        check("busrst_before", {31'd0, o_usb_reset}, 32'd0);
        @(posedge clk); #1;
        usb_se0 = 1'b0;
        @(negedge clk);
        check("busrst_rise", {31'd0, o_usb_reset}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busrst_hold", {31'd0, o_usb_reset}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("busrst_fall", {31'd0, o_usb_reset}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 20);

        // SE0 for 30 cycles: too short for a bus reset.
        usb_se0 = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        usb_se0 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("busrst_short", {31'd0, o_usb_reset}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 20);

        // Receiver recovers for a normal packet afterwards.
        dv0 = n_dv; eop0 = n_eop; err0 = n_err;
        push(K_DV, 8'h3C); push(K_EOP, 8'h00);
        send_sync(); send_byte(8'h3C); send_eop();
        counts("final", dv0, eop0, err0, 1, 1, 0);
        check("final_data", {24'd0, last_data}, 32'h0000_003C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usb_rx_phy.md
Name: usb_rx_phy

Overview:
- Low-speed (1.5 Mbit/s) USB receive front end, directly upstream of the SoC USB device core.
- Takes the raw pad-level line state (J/K and SE0) and synchronizes it.
- Recovers bit timing by oversampling, detects SYNC, NRZI-decodes, removes stuffed bits, and assembles bytes.
- Delivers bytes plus packet framing (EOP, error) and bus-reset detection to the protocol engine.

Parameters:
- OVERSAMPLE, 10: clock cycles per USB bit (15 MHz / 1.5 Mbit/s); must be ≥ 4.
- SAMPLE_PHASE, 5: phase-counter value at which a bit is sampled; must be < OVERSAMPLE.
- SYNC_MIN_ZEROS, 5: minimum decoded 0s before the closing 1 of SYNC.
- RESET_CYCLES, 38: consecutive SE0 cycles that flag a bus reset (≈2.5 µs at 15 MHz).

Ports:
- i_clk, in, 1: system clock (15 MHz).
- i_rst_n, in, 1: asynchronous active-low reset.
- i_usb_j_not_k, in, 1: raw line state, 1 = J, asynchronous to i_clk.
- i_usb_se0, in, 1: raw SE0 indication, asynchronous; takes priority over i_usb_j_not_k.
- i_tx_active, in, 1: transmitter driving the bus; receiver is held idle while high.
- o_active, out, 1: packet in progress (SYNC seen, EOP not yet seen).
- o_data, out, 8: received byte, LSB = first bit on the wire.
- o_data_valid, out, 1: one-cycle strobe qualifying o_data.
- o_eop, out, 1: one-cycle strobe at a valid end of packet.
- o_err, out, 1: one-cycle strobe on a stuff error, partial byte, or malformed EOP.
- o_usb_reset, out, 1: level; high while SE0 has persisted ≥ RESET_CYCLES.

Behaviour:
- Reset (i_rst_n low, asynchronous): all outputs 0, FSM in IDLE, phase counter 0, synchronizers loaded with J (j=1, se0=0).
- Synchronizer: two flops on each of j and se0. The derived line state is SE0 if se0_s, otherwise J/K from j_s.
- Phase counter (0..OVERSAMPLE-1):
  - Cleared to 0 on any change of the synchronized line state.
  - Otherwise increments and wraps OVERSAMPLE-1 → 0.
  - A bit sample is taken in the cycle the counter equals SAMPLE_PHASE. That gives one sample per bit, re-aligned on every edge.
- NRZI decode: decoded bit = 1 if the sampled J/K equals the previous sampled J/K, else 0. The previous-state register is preset to J on entering SYNC.
- FSM states IDLE, SYNC, DATA, EOP, WAIT_J:
  - IDLE: on the first K sample, go to SYNC with zero-count = 1.
  - SYNC:
    - Decoded 0: increment zero-count (saturating).
    - Decoded 1 with zero-count ≥ SYNC_MIN_ZEROS: go to DATA and assert o_active. Bit count and ones count are cleared.
    - Decoded 1 with fewer zeros: return to IDLE silently.
    - SE0 sample: return to IDLE silently.
  - DATA, on a J/K sample:
    - If ones-count == 6, the bit is a stuff bit. Decoded 0: discard it and clear ones-count. Decoded 1: strobe o_err, drop o_active, go to WAIT_J.
    - Otherwise shift the bit into the byte (LSB first). Ones-count is incremented on 1 and cleared on 0.
    - On the 8th bit, o_data_valid is strobed the cycle after that sample, with o_data stable until the next strobe.
  - DATA, on an SE0 sample: go to EOP with se0-bit-count = 1.
  - EOP:
    - SE0 sample: increment se0-bit-count. If it exceeds 2, strobe o_err, drop o_active, go to WAIT_J.
    - J sample: strobe o_eop, drop o_active, go to IDLE. If the bit count ≠ 0 at SE0 entry, o_err is also strobed in the same cycle.
    - K sample: strobe o_err, drop o_active, go to WAIT_J.
  - WAIT_J: stay until a J sample, then go to IDLE.
- i_tx_active high: the FSM is forced to IDLE within 1 cycle and o_active is cleared. No strobes are generated and no o_err is raised for the aborted packet.
- Bus reset detection:
  - Independent SE0 cycle counter, saturating, cleared when se0_s = 0.
  - o_usb_reset rises when the count reaches RESET_CYCLES and falls the cycle after se0_s drops.
  - Not gated by i_tx_active.
- Latency: pad edge to synchronized state is 2 cycles. Last data bit sample to o_data_valid is 1 cycle.
- Strobes are never simultaneous, except o_eop with o_err as described under EOP.

Decomposition:
- Shared package usb_pkg holds:
  - Line-state encoding LS_J / LS_K / LS_SE0 (2 bits).
  - RX FSM state enum.
  - Constant STUFF_LIMIT = 6.
- Natural sub-module usb_rx_dpll: synchronizer, line-state derivation, phase counter. Outputs line state plus a sample strobe.
- The top level holds the FSM, NRZI decode, unstuffing, byte assembly and reset counter.

Test Plan:
- Idle J, then SYNC KJKJKJKK + byte 0xA5 + SE0 SE0 J at 10 cycles/bit → o_active high after SYNC, o_data_valid once with o_data = 0xA5, o_eop strobe, o_err = 0.
- Data byte 0xFF followed by 0x3F → stuffed 0 after six 1s is removed; o_data = 0xFF then 0x3F; no o_err.
- Seven consecutive 1s (stuff bit missing) → o_err strobe, o_active low, no further o_data_valid until the next SYNC.
- Bit period jittered to 9 and 11 cycles on alternating bits → all bytes received correctly, confirming re-alignment on edges.
- SE0 held 40 cycles → o_usb_reset high from cycle 38 (+2 synchronizer cycles), low 1 cycle after SE0 ends. SE0 held 30 cycles → o_usb_reset stays 0.
- SYNC + 4 data bits + EOP → o_eop and o_err in the same cycle, no o_data_valid. Assert i_tx_active mid-packet → o_active falls next cycle with no strobes.
